// File: rtl/point_mapper_if.sv
// point_mapper_if: point stream, framebuffer bus and status signals of the point mapper.
interface point_mapper_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       xval;
  logic [5:0]       yval;
  logic             pvalid;
  logic             donedge;
  logic             draw_mode;
  logic             clear_start;
  logic             done_point;
  logic [10:0]      mem_addr;
  logic             mem_re;
  logic [7:0]       mem_rdata;
  logic             mem_we;
  logic [7:0]       mem_wdata;
  logic             busy;
  logic [7:0]       edge_count;
  logic [CNT_W-1:0] pixel_count;
  modport slave (
    input  xval, yval, pvalid, donedge, draw_mode, clear_start, mem_rdata,
    output done_point, mem_addr, mem_re, mem_we, mem_wdata, busy, edge_count, pixel_count
  );
  modport master (
    output xval, yval, pvalid, donedge, draw_mode, clear_start, mem_rdata,
    input  done_point, mem_addr, mem_re, mem_we, mem_wdata, busy, edge_count, pixel_count
  );
endinterface

// File: rtl/point_mapper.sv
// point_mapper: rasterises edge points into a 1bpp framebuffer via byte read-modify-write,
// with a full-frame clear sweep and edge/pixel statistics.
module point_mapper #(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input logic       clock,
  input logic       reset,
  point_mapper_if.slave pm
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ACK, CLEAR} state_t;
  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 2);
  state_t           state_q, state_d;
  logic [7:1]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic             mode_q, mode_d;
  logic [1:0]       wait_q, wait_d;
  logic [10:0]      clr_q, clr_d;
  logic [7:0]       edge_q, edge_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic             don_q;
  logic [10:0]      addr;
  logic [7:0]       mask;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    wait_d  = wait_q;
    clr_d   = clr_q;
    pix_d   = pix_q;
    edge_d  = (pm.donedge && !don_q && !(&edge_q)) ? edge_q + 8'd1 : edge_q;
    case (state_q)
      IDLE: begin
        if (pm.clear_start) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else if (pm.pvalid) begin
          state_d = READ;
          x_d     = pm.xval[7:1];
          y_d     = pm.yval;
          mode_d  = pm.draw_mode;
        end
      end
      READ: begin
        state_d = (RD_LATENCY == 1) ? WRITE : WAIT;
        wait_d  = WAIT_INIT;
      end
      WAIT: begin
        state_d = (wait_q == 2'd0) ? WRITE : WAIT;
        wait_d  = wait_q - 2'd1;
      end
      WRITE: begin
        state_d = ACK;
        pix_d   = (&pix_q) ? pix_q : pix_q + 1'b1;
      end
      ACK: state_d = IDLE;
      CLEAR: begin
        state_d = (&clr_q) ? IDLE : CLEAR;
        clr_d   = clr_q + 11'd1;
        pix_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
      wait_q  <= '0;
      clr_q   <= '0;
      edge_q  <= '0;
      pix_q   <= '0;
      don_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
      clr_q   <= clr_d;
      edge_q  <= edge_d;
      pix_q   <= pix_d;
      don_q   <= pm.donedge;
    end
  end
  assign addr = {y_q, x_q[7:3]};
  assign mask = 8'b11 << {x_q[2:1], 1'b0};
  assign pm.mem_re      = state_q == READ;
  assign pm.mem_we      = state_q == WRITE || state_q == CLEAR;
  assign pm.mem_addr    = (state_q == READ || state_q == WAIT || state_q == WRITE) ? addr :
                          state_q == CLEAR ? clr_q : '0;
  // WRITE falls on the cycle read data becomes valid, so the live bus value is merged directly
  assign pm.mem_wdata   = state_q != WRITE ? '0 :
                          mode_q ? (pm.mem_rdata | mask) : (pm.mem_rdata & ~mask);
  assign pm.done_point  = state_q == ACK;
  assign pm.busy        = state_q != IDLE;
  assign pm.edge_count  = edge_q;
  assign pm.pixel_count = pix_q;
endmodule

// File: tb/tb_point_mapper.sv
// tb_point_mapper: random and directed points checked against a pixel-bitmap model of the frame.
module tb_point_mapper;
  localparam int L  = 1;
  localparam int CW = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  point_mapper_if #(.CNT_W(CW)) pm ();
  point_mapper #(.RD_LATENCY(L), .CNT_W(CW)) dut (.clock(clock), .reset(reset), .pm(pm));
  logic [7:0]  mem [2048];
  logic [7:0]  rpipe [L];
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [7:0]  pre_val = '0;
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_val;
    if (pm.mem_we) mem[pm.mem_addr] <= pm.mem_wdata;
    rpipe[0] <= pm.mem_re ? mem[pm.mem_addr] : 8'($urandom);
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign pm.mem_rdata = rpipe[L-1];
  bit          px [64][256];
  int unsigned pix_exp = 0;
  int unsigned edge_exp = 0;
  logic        d_prev = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        watch = 1'b0;
  int          we_bad = 0;
  always @(negedge clock) if (watch && pm.mem_we) we_bad++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] byte_of(input int y, input int xb);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = px[y][xb*8+b];
    return r;
  endfunction
  task automatic drive_done(input logic v);
    if (v && !d_prev && edge_exp < 255) edge_exp++;
    d_prev = v;
    pm.donedge = v;
  endtask
  task automatic preload(input int y, input int xb, input logic [7:0] v);
    pre_addr = 11'(y*32 + xb);
    pre_val  = v;
    pre_we   = 1'b1;
    for (int b = 0; b < 8; b++) px[y][xb*8+b] = v[b];
    @(negedge clock);
    pre_we = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 5000 && pm.busy; i++) @(negedge clock);
    if (pm.busy) check("idle_timeout", pm.busy, 0);
  endtask
  task automatic follow(input logic [7:0] x, input logic [5:0] y, input logic m, output logic [7:0] wd);
    int a;
    a = int'(y)*32 + int'(x)/8;
    check("re", pm.mem_re, 1);
    check("re_addr", pm.mem_addr, a);
    for (int k = 1; k <= L; k++) begin
      @(negedge clock);
      if (k < L) check("wait_quiet", pm.mem_re | pm.mem_we, 0);
    end
    px[y][int'(x) & 254] = m;
    px[y][int'(x) | 1]   = m;
    check("we", pm.mem_we, 1);
    check("we_addr", pm.mem_addr, a);
    check("wdata", pm.mem_wdata, byte_of(y, int'(x)/8));
    wd = pm.mem_wdata;
    if (pix_exp < (1 << CW) - 1) pix_exp++;
    @(negedge clock);
    check("done", pm.done_point, 1);
    check("pix", pm.pixel_count, pix_exp);
    @(negedge clock);
    check("done_pulse", pm.done_point, 0);
    check("idle", pm.busy, 0);
  endtask
  task automatic plot(input logic [7:0] x, input logic [5:0] y, input logic m, input logic dn,
                      output logic [7:0] wd);
    wait_idle();
    pm.xval = x;
    pm.yval = y;
    pm.draw_mode = m;
    pm.pvalid = 1'b1;
    drive_done(dn);
    @(negedge clock);
    pm.pvalid = 1'b0;
    follow(x, y, m, wd);
  endtask
  initial begin
    logic [7:0] wd;
    int bad;
    pm.xval = '0; pm.yval = '0; pm.pvalid = 1'b0; pm.donedge = 1'b0;
    pm.draw_mode = 1'b0; pm.clear_start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2048; i++) preload(i / 32, i % 32, 8'($urandom));
    check("rst_re", pm.mem_re, 0);
    check("rst_we", pm.mem_we, 0);
    check("rst_addr", pm.mem_addr, 0);
    check("rst_wdata", pm.mem_wdata, 0);
    check("rst_busy", pm.busy, 0);
    check("rst_done", pm.done_point, 0);
    check("rst_edges", pm.edge_count, 0);
    check("rst_pix", pm.pixel_count, 0);
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      drive_done(1'($urandom));
      @(negedge clock);
      bad += int'(pm.mem_re | pm.mem_we | pm.busy | pm.done_point);
    end
    check("idle_quiet", bad, 0);
    check("idle_edges", pm.edge_count, edge_exp);
    preload(5, 1, 8'h81);
    plot(8'h0A, 6'd5, 1'b1, 1'b0, wd);
    check("tp_set", wd, 8'h8D);
    check("tp_pix1", pm.pixel_count, 1);
    preload(5, 1, 8'h0F);
    plot(8'h0A, 6'd5, 1'b0, 1'b0, wd);
    check("tp_clr", wd, 8'h03);
    preload(63, 31, 8'h00);
    plot(8'd254, 6'd63, 1'b1, 1'b1, wd);
    check("tp_corner", wd, 8'hC0);
    plot(8'd0, 6'd0, 1'b1, 1'b0, wd);
    repeat (200) plot(8'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), wd);
    check("rand_edges", pm.edge_count, edge_exp);
    wait_idle();
    pm.clear_start = 1'b1;
    pm.pvalid = 1'b1;
    pm.xval = 8'h37; pm.yval = 6'd9; pm.draw_mode = 1'b1;
    @(negedge clock);
    pm.clear_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      pm.clear_start = (i == 1000);
      bad += int'(!pm.mem_we || pm.mem_addr != 11'(i) || pm.mem_wdata != 8'h00 ||
                  !pm.busy || pm.done_point);
      @(negedge clock);
    end
    pm.clear_start = 1'b0;
    check("clear_sweep", bad, 0);
    check("clear_idle", pm.busy, 0);
    check("clear_pix", pm.pixel_count, 0);
    pix_exp = 0;
    for (int y = 0; y < 64; y++) for (int x = 0; x < 256; x++) px[y][x] = 1'b0;
    @(negedge clock);
    pm.pvalid = 1'b0;
    follow(8'h37, 6'd9, 1'b1, wd);
    plot(8'h36, 6'd9, 1'b0, 1'b0, wd);
    wait_idle();
    pm.xval = 8'h40; pm.yval = 6'd20; pm.draw_mode = 1'b1; pm.pvalid = 1'b1;
    @(negedge clock);
    pm.pvalid = 1'b0;
    drive_done(1'b0);
    #2 reset = 1'b0;
    watch = 1'b1;
    #1;
    check("abort_busy", pm.busy, 0);
    check("abort_re", pm.mem_re, 0);
    check("abort_edges", pm.edge_count, 0);
    check("abort_pix", pm.pixel_count, 0);
    @(negedge clock);
    reset = 1'b1;
    edge_exp = 0;
    pix_exp = 0;
    d_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive_done(1'b1);
      @(negedge clock);
      drive_done(1'b0);
      @(negedge clock);
      if (i == 99) check("edges_100", pm.edge_count, edge_exp);
    end
    check("edge_sat", pm.edge_count, 255);
    check("edge_model", pm.edge_count, edge_exp);
    check("no_we_after_reset", we_bad, 0);
    check("post_rst_pix", pm.pixel_count, 0);
    watch = 1'b0;
    plot(8'h40, 6'd20, 1'b1, 1'b0, wd);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
